// File: rtl/gcd_if.sv
// Request/result bundle between a requester and the GCD engine.
// Request: go with x/y/mode is taken only while the engine is idle; the result is held under d_valid until d_ack.
interface gcd_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             go;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             mode;
    logic             busy;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             d_ack;
    logic             zero;
    logic [CNT_W-1:0] iter;
    logic [2:0]       state;

    modport master (
        output go, x, y, mode, d_ack,
        input  busy, d, d_valid, zero, iter, state
    );

    modport slave (
        input  go, x, y, mode, d_ack,
        output busy, d, d_valid, zero, iter, state
    );
endinterface

// File: rtl/gcd_engine.sv
// Iterative GCD unit: subtractive Euclid or binary Stein, selected per request.
// Reports a saturating iteration count and flags the all-zero case.
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    gcd_if.slave bus
);
    localparam int K_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SUB   = 3'd2,
        BIN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             m_q;
    logic [K_W-1:0]   k_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] d_q;
    logic             d_valid_q;
    logic             zero_q;
    logic [CNT_W-1:0] iter_q;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    assign bus.busy    = busy_q;
    assign bus.d       = d_q;
    assign bus.d_valid = d_valid_q;
    assign bus.zero    = zero_q;
    assign bus.iter    = iter_q;
    assign bus.state   = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            m_q       <= 1'b0;
            k_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            d_q       <= '0;
            d_valid_q <= 1'b0;
            zero_q    <= 1'b0;
            iter_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.go) begin
                        x_q     <= bus.x;
                        y_q     <= bus.y;
                        m_q     <= bus.mode;
                        k_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    // A zero operand short-circuits: gcd(0,v) = v without iterating.
                    if (x_q == '0 || y_q == '0) begin
                        d_q       <= x_q | y_q;
                        zero_q    <= (x_q == '0) && (y_q == '0);
                        iter_q    <= cnt_q;
                        d_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        state_q <= m_q ? BIN : SUB;
                    end
                end
                SUB: begin
                    if (x_q == y_q) begin
                        d_q       <= x_q;
                        iter_q    <= cnt_q;
                        d_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (x_q > y_q) begin
                        x_q   <= x_q - y_q;
                        cnt_q <= cnt_next;
                    end else begin
                        y_q   <= y_q - x_q;
                        cnt_q <= cnt_next;
                    end
                end
                BIN: begin
                    // K counts shared factors of two removed; restore them on exit.
                    if (x_q == y_q) begin
                        d_q       <= x_q << k_q;
                        iter_q    <= cnt_q;
                        d_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_next;
                        if (!x_q[0] && !y_q[0]) begin
                            x_q <= x_q >> 1;
                            y_q <= y_q >> 1;
                            k_q <= k_q + 1'b1;
                        end else if (!x_q[0]) begin
                            x_q <= x_q >> 1;
                        end else if (!y_q[0]) begin
                            y_q <= y_q >> 1;
                        end else if (x_q > y_q) begin
                            x_q <= (x_q - y_q) >> 1;
                        end else begin
                            y_q <= (y_q - x_q) >> 1;
                        end
                    end
                end
                DONE: begin
                    if (bus.d_ack) begin
                        d_valid_q <= 1'b0;
                        zero_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_engine.sv
// Directed-vector bench for gcd_engine: latency, handshake hold, zero paths,
// saturation, back-to-back requests and asynchronous abort.
module tb_gcd_engine;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;
    localparam int EDGE_LIMIT = 70000;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [WIDTH-1:0] exp_q[$];

    gcd_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    gcd_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    // Issues one request at the current time (just after an edge, engine idle),
    // waits for the result, checks it, optionally holds, then acknowledges.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                          input logic m, input logic [WIDTH-1:0] ed, input logic ez,
                          input logic [CNT_W-1:0] ei, input int ee, input int hold,
                          input bit pulse_go);
        int edges;
        int busy_low;
        logic [WIDTH-1:0] expd;
        exp_q.push_back(ed);
        bus.go   = 1'b1;
        bus.x    = xv;
        bus.y    = yv;
        bus.mode = m;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        edges = 0;
        busy_low = 0;
        while (!bus.d_valid && edges < EDGE_LIMIT) begin
            @(posedge clk);
            #1;
            edges++;
            if (!bus.busy) busy_low++;
            if (pulse_go && edges == 1) begin
                bus.go = 1'b1; bus.x = 16'd3; bus.y = 16'd3; bus.mode = 1'b1;
            end
            if (pulse_go && edges == 3) bus.go = 1'b0;
        end
        bus.go = 1'b0;
        expd = exp_q.pop_front();
        check({tag, "_edge"}, edges, ee);
        check({tag, "_d"}, bus.d, expd);
        check({tag, "_zero"}, bus.zero, ez);
        check({tag, "_iter"}, bus.iter, ei);
        check({tag, "_busy_run"}, busy_low, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, bus.d_valid, 1);
            check({tag, "_hold_d"}, bus.d, expd);
        end
        bus.d_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.d_ack = 1'b0;
        check({tag, "_ack_valid"}, bus.d_valid, 0);
        check({tag, "_ack_zero"}, bus.zero, 0);
        check({tag, "_ack_busy"}, bus.busy, 0);
        check({tag, "_ack_d_kept"}, bus.d, expd);
        check({tag, "_ack_iter_kept"}, bus.iter, ei);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.go = 1'b0; bus.x = '0; bus.y = '0; bus.mode = 1'b0; bus.d_ack = 1'b0;
        reset = 1'b1;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.d_valid, 0);
        check("rst_d", bus.d, 0);
        check("rst_iter", bus.iter, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_state", bus.state, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Abort mid-SUB on gcd(12,8): reset acts between edges.
        bus.go = 1'b1; bus.x = 16'd12; bus.y = 16'd8; bus.mode = 1'b0;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort_busy_before", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.d_valid, 0);
        check("abort_state", bus.state, 0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("sub_12_8", 16'd12, 16'd8, 1'b0, 16'd4, 1'b0, 8'd2, 4, 3, 1'b0);
        // Back-to-back: each following request is raised in the first idle cycle.
        run_op("bin_12_8", 16'd12, 16'd8, 1'b1, 16'd4, 1'b0, 8'd4, 6, 0, 1'b0);
        run_op("bin_35_14", 16'd35, 16'd14, 1'b1, 16'd7, 1'b0, 8'd3, 5, 0, 1'b0);
        run_op("zero_x", 16'd0, 16'd9, 1'b0, 16'd9, 1'b0, 8'd0, 1, 0, 1'b0);
        run_op("zero_both", 16'd0, 16'd0, 1'b1, 16'd0, 1'b1, 8'd0, 1, 1, 1'b0);
        run_op("sub_27_18", 16'd27, 16'd18, 1'b0, 16'd9, 1'b0, 8'd2, 4, 0, 1'b0);
        run_op("go_ignored", 16'd12, 16'd8, 1'b0, 16'd4, 1'b0, 8'd2, 4, 0, 1'b1);
        run_op("sat", 16'd65535, 16'd1, 1'b0, 16'd1, 1'b0, 8'd255, 65536, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
